crossbar_ctl: RTL and testbench

//  Transaction controller upstream of the crossbar datapath: drives its set_owner/clr_owner.

---
 rtl/crossbar_pkg.sv | 33 +++
 rtl/crossbar_beat_cnt.sv | 35 +++
 rtl/crossbar_ctl.sv | 169 ++++++++++++++++
 tb/tb_crossbar_ctl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_pkg.sv
// Shared types and TileLink constants for the crossbar transaction controller.
// Beat-count helper converts a clamped log2 transfer size into bus beats.
package crossbar_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StReq,
    StDataA,
    StResp
  } ctl_state_t;

  localparam logic [2:0] TL_PUT_FULL     = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL  = 3'd1;
  localparam logic [2:0] TL_GET          = 3'd4;

  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  // Wide enough for a 3-bit size even with a byte-wide bus (128 beats).
  localparam int unsigned CNT_W = 8;

  function automatic logic [CNT_W-1:0] tl_beats(input logic [2:0]  size,
                                                input int unsigned beat_log2,
                                                input int unsigned max_size);
    int unsigned sz;
    sz = 32'(size);
    if (sz > max_size) sz = max_size;
    if (sz <= beat_log2) return CNT_W'(1);
    return CNT_W'(1) << (sz - beat_log2);
  endfunction

endpackage

// File: rtl/crossbar_beat_cnt.sv
// Loadable down-counter for outstanding beats; 'last' flags the final beat.
// Load takes priority over decrement; decrement saturates at zero.
module crossbar_beat_cnt
  import crossbar_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == CNT_W'(1));

endmodule

// File: rtl/crossbar_ctl.sv
// Crossbar transaction controller: pulses set_owner/clr_owner around each A/D transaction.
// Optional watchdog abort is enabled by defining CROSSBAR_TIMEOUT_EN.
module crossbar_ctl
  import crossbar_pkg::*;
#(
  parameter int unsigned NMASTER   = 16,
  parameter int unsigned BEAT_LOG2 = 3,
  parameter int unsigned MAX_SIZE  = 6,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NMASTER-1:0] request,
  input  logic               a_valid,
  input  logic               a_ready,
  input  logic [2:0]         a_opcode,
  input  logic [2:0]         a_size,
  input  logic               d_valid,
  input  logic               d_ready,
  output logic               set_owner,
  output logic               clr_owner,
  output logic               busy,
  output logic               timeout_err
);

  ctl_state_t state_q, state_d;

  logic             a_fire, d_fire;
  logic             is_put, is_get;
  logic [CNT_W-1:0] beats, d_need;
  logic             a_load, a_dec, a_last;
  logic             d_load, d_dec, d_last;
  logic [CNT_W-1:0] a_load_val, d_load_val;
  logic             wd_abort;

  assign a_fire = a_valid & a_ready;
  assign d_fire = d_valid & d_ready;
  assign is_put = (a_opcode == TL_PUT_FULL) || (a_opcode == TL_PUT_PARTIAL);
  assign is_get = (a_opcode == TL_GET);
  assign beats  = tl_beats(a_size, BEAT_LOG2, MAX_SIZE);
  // Only Get returns multiple D beats; Puts and unknown opcodes get one ack.
  assign d_need = is_get ? beats : CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    set_owner  = 1'b0;
    clr_owner  = 1'b0;
    a_load     = 1'b0;
    a_load_val = '0;
    a_dec      = 1'b0;
    d_load     = 1'b0;
    d_load_val = '0;
    d_dec      = 1'b0;
    case (state_q)
      StIdle: begin
        if (|request) begin
          set_owner = 1'b1;
          state_d   = StArb;
        end
      end
      StArb: state_d = StReq;
      StReq: begin
        if (a_fire) begin
          if (is_put && (beats > CNT_W'(1))) begin
            a_load     = 1'b1;
            a_load_val = beats - CNT_W'(1);
            state_d    = StDataA;
          end else if (d_fire && (d_need == CNT_W'(1))) begin
            // Zero-latency slave: A and its only D beat in the same cycle.
            clr_owner = 1'b1;
            state_d   = StIdle;
          end else begin
            d_load     = 1'b1;
            d_load_val = d_fire ? (d_need - CNT_W'(1)) : d_need;
            state_d    = StResp;
          end
        end
      end
      StDataA: begin
        if (a_fire) begin
          a_dec = 1'b1;
          if (a_last) begin
            d_load     = 1'b1;
            d_load_val = CNT_W'(1);
            state_d    = StResp;
          end
        end
      end
      StResp: begin
        if (d_fire) begin
          d_dec = 1'b1;
          if (d_last) begin
            clr_owner = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (wd_abort) begin
      clr_owner = 1'b1;
      state_d   = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy = (state_q != StIdle) | set_owner;

  crossbar_beat_cnt u_a_left (
    .clk      (clk),
    .rst      (rst),
    .load     (a_load),
    .load_val (a_load_val),
    .dec      (a_dec),
    .last     (a_last)
  );

  crossbar_beat_cnt u_d_left (
    .clk      (clk),
    .rst      (rst),
    .load     (d_load),
    .load_val (d_load_val),
    .dec      (d_dec),
    .last     (d_last)
  );

`ifdef CROSSBAR_TIMEOUT_EN
  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WdW-1:0] wd_q, wd_d;
  logic           wd_active;

  assign wd_active = (state_q == StReq) || (state_q == StDataA) || (state_q == StResp);
  // A fire in the abort cycle counts as progress and suppresses the abort.
  assign wd_abort  = wd_active && !(a_fire || d_fire) && (wd_q == WdW'(TIMEOUT - 1));

  always_comb begin
    wd_d = wd_q;
    if (!wd_active || a_fire || d_fire) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + WdW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign timeout_err = wd_abort;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign wd_abort       = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_crossbar_ctl.sv
// Scoreboard bench for crossbar_ctl: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them and flags any unexpected pulse.
module tb_crossbar_ctl;
  import crossbar_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] request;
  logic        a_valid, a_ready, d_valid, d_ready;
  logic [2:0]  a_opcode, a_size;
  logic        set_owner, clr_owner, busy, timeout_err;

  typedef struct {
    int cyc;
    bit so;
    bit co;
    bit te;
    bit bz;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   done     = 1'b0;

  crossbar_ctl #(
    .NMASTER   (16),
    .BEAT_LOG2 (3),
    .MAX_SIZE  (6),
    .TIMEOUT   (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .request     (request),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_opcode    (a_opcode),
    .a_size      (a_size),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .set_owner   (set_owner),
    .clr_owner   (clr_owner),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare at the cycle an expectation was queued for.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        n_checks++;
        $display("FAIL stale_expect cyc=%0d never sampled", e.cyc);
      end
      if (done) begin
        while (sb.size() > 0) begin
          e = sb.pop_front();
          n_checks++;
          $display("FAIL missing_expect cyc=%0d never sampled", e.cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_checks++;
        if ({set_owner, clr_owner, timeout_err, busy} === {e.so, e.co, e.te, e.bz}) begin
          n_pass++;
        end else begin
          $display("FAIL outputs cyc=%0d set/clr/terr/busy got %b%b%b%b want %b%b%b%b", cyc,
                   set_owner, clr_owner, timeout_err, busy, e.so, e.co, e.te, e.bz);
        end
      end else if (set_owner || clr_owner || timeout_err) begin
        n_checks++;
        $display("FAIL unexpected_pulse cyc=%0d set/clr/terr got %b%b%b want 000", cyc,
                 set_owner, clr_owner, timeout_err);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout bench did not finish");
    $fatal(1, "bench timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input bit so, input bit co, input bit te, input bit bz);
    exp_t e;
    e = '{cyc, so, co, te, bz};
    sb.push_back(e);
  endtask

  // Full transaction with always-ready handshakes; na/nd are hand-computed beat counts.
  task automatic txn(input logic [15:0] req, input logic [2:0] op, input logic [2:0] sz,
                     input int na, input int nd);
    request = req;   chk(1, 0, 0, 1); step();
    request = '0;    chk(0, 0, 0, 1); step();
    a_opcode = op;
    a_size   = sz;
    for (int i = 0; i < na; i++) begin
      a_valid = 1'b1; a_ready = 1'b1; chk(0, 0, 0, 1); step();
    end
    a_valid = 1'b0; a_ready = 1'b0;
    for (int i = 0; i < nd; i++) begin
      d_valid = 1'b1; d_ready = 1'b1; chk(0, (i == nd - 1), 0, 1); step();
    end
    d_valid = 1'b0; d_ready = 1'b0; chk(0, 0, 0, 0); step();
  endtask

  initial begin
    int fires;
    rst = 1'b1; request = '0;
    a_valid = 1'b0; a_ready = 1'b0; a_opcode = TL_GET; a_size = 3'd0;
    d_valid = 1'b0; d_ready = 1'b0;
    step(); step();
    rst = 1'b0; chk(0, 0, 0, 0); step();

    // Get size=3, slave acks two cycles after the A fire.
    request = 16'h0004; chk(1, 0, 0, 1); step();
    request = '0;       chk(0, 0, 0, 1); step();
    a_valid = 1'b1; a_ready = 1'b1; a_opcode = TL_GET; a_size = 3'd3; chk(0, 0, 0, 1); step();
    a_valid = 1'b0; a_ready = 1'b0; chk(0, 0, 0, 1); step();
    d_valid = 1'b1; d_ready = 1'b1; chk(0, 1, 0, 1); step();
    d_valid = 1'b0; d_ready = 1'b0; chk(0, 0, 0, 0); step();

    // Get size=6: eight D beats with d_ready toggling; stray A traffic in RESP ignored.
    request = 16'h0010; chk(1, 0, 0, 1); step();
    request = '0;       chk(0, 0, 0, 1); step();
    a_valid = 1'b1; a_ready = 1'b1; a_opcode = TL_GET; a_size = 3'd6; chk(0, 0, 0, 1); step();
    fires = 0;
    d_valid = 1'b1;
    for (int i = 0; fires < 8 && i < 64; i++) begin
      d_ready = i[0];
      if (d_ready) fires++;
      chk(0, (d_ready && fires == 8), 0, 1); step();
    end
    a_valid = 1'b0; a_ready = 1'b0; d_valid = 1'b0; d_ready = 1'b0;
    chk(0, 0, 0, 0); step();

    // PutFull size=5: four A beats (one stall), D held high early must be ignored.
    request = 16'h0100; chk(1, 0, 0, 1); step();
    request = '0;       chk(0, 0, 0, 1); step();
    a_valid = 1'b1; a_ready = 1'b1; a_opcode = TL_PUT_FULL; a_size = 3'd5;
    d_valid = 1'b1; d_ready = 1'b1; chk(0, 0, 0, 1); step();
    a_ready = 1'b0; chk(0, 0, 0, 1); step();
    a_ready = 1'b1; chk(0, 0, 0, 1); step();
    chk(0, 0, 0, 1); step();
    chk(0, 0, 0, 1); step();
    a_valid = 1'b0; a_ready = 1'b0; chk(0, 1, 0, 1); step();
    d_valid = 1'b0; d_ready = 1'b0; chk(0, 0, 0, 0); step();

    // Zero-latency slave with request held: clr then set_owner on the next cycle.
    request = 16'h0002; chk(1, 0, 0, 1); step();
    chk(0, 0, 0, 1); step();
    a_valid = 1'b1; a_ready = 1'b1; a_opcode = TL_GET; a_size = 3'd3;
    d_valid = 1'b1; d_ready = 1'b1; chk(0, 1, 0, 1); step();
    a_valid = 1'b0; d_valid = 1'b0; chk(1, 0, 0, 1); step();

    // Reset in RESP with d_left=3 abandons silently; then a fresh request.
    request = '0; chk(0, 0, 0, 1); step();
    a_valid = 1'b1; a_size = 3'd5; chk(0, 0, 0, 1); step();
    a_valid = 1'b0; d_valid = 1'b1; chk(0, 0, 0, 1); step();
    d_valid = 1'b0; rst = 1'b1; step();
    rst = 1'b0; chk(0, 0, 0, 0); step();
    txn(16'h8000, TL_GET, 3'd0, 1, 1);

    // Other opcode, clamped sizes, single-beat Put.
    txn(16'h0001, 3'd2, 3'd6, 1, 1);
    txn(16'h0020, TL_PUT_PARTIAL, 3'd7, 8, 1);
    txn(16'h0400, TL_GET, 3'd7, 1, 8);
    txn(16'h0800, TL_PUT_FULL, 3'd2, 1, 1);

    // Slave never answers D.
    request = 16'h0040; chk(1, 0, 0, 1); step();
    request = '0;       chk(0, 0, 0, 1); step();
    a_valid = 1'b1; a_ready = 1'b1; a_opcode = TL_GET; a_size = 3'd3; chk(0, 0, 0, 1); step();
    a_valid = 1'b0; a_ready = 1'b0;
`ifdef CROSSBAR_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      chk(0, 0, 0, 1); step();
    end
    chk(0, 1, 1, 1); step();
    chk(0, 0, 0, 0); step();
`else
    for (int k = 0; k < 40; k++) begin
      chk(0, 0, 0, 1); step();
    end
    d_valid = 1'b1; d_ready = 1'b1; chk(0, 1, 0, 1); step();
    d_valid = 1'b0; d_ready = 1'b0; chk(0, 0, 0, 0); step();
`endif

    step();
    done = 1'b1;
  end

endmodule
